memdep_lfst: RTL and testbench
==============================

MEMDEP_LFST -- requirements
Module: memdep_lfst

Interface
REQ-001 SHALL have parameter RENAME_WIDTH, default 4, the number of rename slots per cycle.
REQ-002 SHALL have parameter LFST_SIZE, default `LFST_SIZE (32), the number of table entries; ssid width is $clog2(LFST_SIZE).
REQ-003 SHALL have parameter ISSUE_WIDTH, default 2, the number of store-issue clear ports.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_lookup_vld  in  RENAME_WIDTH  per-slot lookup request; the slot carries a predicted store set.
REQ-007 i_lookup_ssid  in  RENAME_WIDTH x 5  per-slot store-set id.
REQ-008 i_lookup_isStore  in  RENAME_WIDTH  slot is a store and will become the set's last fetched store.
REQ-009 i_lookup_sqIdx  in  RENAME_WIDTH x sqIdx_t  store-queue index of the slot, meaningful only when the slot is a store.
REQ-010 o_dep_vld  out  RENAME_WIDTH  slot must wait on a prior store.
REQ-011 o_dep_sqIdx  out  RENAME_WIDTH x sqIdx_t  store-queue index of that prior store.
REQ-012 i_stIssue_vld / i_stIssue_ssid / i_stIssue_sqIdx  in  ISSUE_WIDTH, ISSUE_WIDTH x 5, ISSUE_WIDTH x sqIdx_t  store issued.
REQ-013 i_squash_vld / i_squash_sqIdx  in  1 / sqIdx_t  squash every store at or younger than the given index.
REQ-014 o_validCount  out  6  number of valid entries; used for performance counters.

Function
REQ-015 Table entry: valid bit plus sqIdx_t.
REQ-016 Lookup SHALL be combinational (0-cycle), reading registered state.
REQ-017 For a slot k with a valid lookup, the response SHALL select the youngest older slot j<k in the same group with i_lookup_vld, i_lookup_isStore and an equal ssid; o_dep_vld=1 and o_dep_sqIdx=i_lookup_sqIdx[j] (intra-group bypass).
REQ-018 If no such slot j exists, o_dep_vld=entry.valid and o_dep_sqIdx=entry.sqIdx.
REQ-019 Each slot that is valid and a store SHALL write {valid=1, sqIdx} to entry[ssid] at the next edge.
REQ-020 When several store slots in one cycle write the same ssid, the highest-numbered slot SHALL win.
REQ-021 A store-issue port SHALL clear entry[ssid].valid at the next edge only when the entry is valid and entry.sqIdx equals i_stIssue_sqIdx; otherwise it has no effect.
REQ-022 A rename write to an ssid SHALL win over an issue clear to the same ssid in the same cycle.
REQ-023 On i_squash_vld, every valid entry whose sqIdx is the same as or younger than i_squash_sqIdx SHALL be invalidated at the next edge.
REQ-024 Age compare: a is younger-or-equal to b iff (a.flipped==b.flipped) ? a.idx>=b.idx : a.idx<b.idx.
REQ-025 While i_squash_vld is asserted, rename writes SHALL be ignored.
REQ-026 While i_squash_vld is asserted, o_dep_vld SHALL be forced to 0.
REQ-027 Issue clears SHALL still apply in a squash cycle.
REQ-028 o_validCount SHALL be a registered popcount of the post-update valid bits, so it lags the table by 0 cycles relative to the registered state.
REQ-029 Lookups with i_lookup_vld=0 SHALL drive o_dep_vld=0 and o_dep_sqIdx=0.

Reset
REQ-030 While rst=0, all valid bits and o_validCount SHALL be 0, and stored sqIdx values SHALL be 0.
REQ-031 Release of reset SHALL be effective at the first clk edge after rst rises.
REQ-032 An update in flight when reset asserts SHALL be discarded.

Structure
REQ-033 sqIdx_t, `LFST_SIZE, `SSIT_SIZE and the ssid type SHALL come from the shared core-common header.
REQ-034 A ssid_t typedef (logic[$clog2(`LFST_SIZE)-1:0]) SHALL be added to the shared header.
REQ-035 The age-compare function SHALL be placed in the shared header for reuse by the load and store queues.
REQ-036 The priority bypass selector SHALL be one sub-module, memdep_bypass_sel, instantiated once per slot.

Verification
REQ-037 Reset, then lookup ssid=3 in slot 0 -> o_dep_vld=0 and o_validCount=0.
REQ-038 Slot 0 store ssid=5 sqIdx={0,10}, slot 2 load ssid=5 in the same cycle -> slot 2 o_dep_vld=1, o_dep_sqIdx={0,10}; next cycle a lookup of ssid=5 returns {0,10}.
REQ-039 Slots 0 and 1 both store ssid=7, sqIdx {0,4} and {0,5} -> the entry holds {0,5}; an issue with sqIdx {0,4} leaves it valid; an issue with {0,5} clears it.
REQ-040 Entries ssid 1/2/3 hold {0,60}/{1,2}/{0,20}; squash at {0,30} -> ssid 1 and 2 invalid, ssid 3 valid, o_validCount=1.
REQ-041 In the same cycle, a rename store to ssid=9 sqIdx={0,8} and an issue clear ssid=9 matching the old entry -> entry=valid {0,8}.
REQ-042 Assert rst mid-cycle while writes are pending -> all entries invalid immediately; after release, lookups return o_dep_vld=0.

Source files
------------

// File: rtl/memdep_lfst_pkg.sv
// memdep_lfst_pkg: shared core types for store-set memory dependence prediction
package memdep_lfst_pkg;
    localparam int LFST_SIZE = 32;
    localparam int SSIT_SIZE = 1024;
    localparam int SQ_IDX_W = 6;
    typedef logic [$clog2(LFST_SIZE)-1:0] ssid_t;
    typedef struct packed {
        logic                flipped;
        logic [SQ_IDX_W-1:0] idx;
    } sqIdx_t;
    // true when a is the same age as or younger than b in the circular store queue
    function automatic logic younger_eq(sqIdx_t a, sqIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx >= b.idx) : (a.idx < b.idx);
    endfunction
endpackage

// File: rtl/memdep_bypass_sel.sv
// memdep_bypass_sel: picks the youngest older same-set store in a rename group
module memdep_bypass_sel
    import memdep_lfst_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 0,
    parameter int SW = 5
) (
    input  logic [N-1:0]         cand,
    input  logic [N-1:0][SW-1:0] ssid,
    input  sqIdx_t [N-1:0]       sq_idx,
    output logic                 hit,
    output sqIdx_t               hit_sq_idx
);
    // ascending scan so the highest older slot overrides earlier matches
    always_comb begin
        hit = 1'b0;
        hit_sq_idx = '0;
        for (int j = 0; j < N; j++)
            if (j < K && cand[j] && ssid[j] == ssid[K]) begin
                hit = 1'b1;
                hit_sq_idx = sq_idx[j];
            end
    end
endmodule

// File: rtl/memdep_lfst.sv
// memdep_lfst: last-fetched-store table with intra-group bypass, issue clear and squash
module memdep_lfst
    import memdep_lfst_pkg::*;
#(
    parameter int RENAME_WIDTH = 4,
    parameter int LFST_SIZE    = memdep_lfst_pkg::LFST_SIZE,
    parameter int ISSUE_WIDTH  = 2,
    localparam int SW = $clog2(LFST_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [RENAME_WIDTH-1:0]          i_lookup_vld,
    input  logic [RENAME_WIDTH-1:0][SW-1:0]  i_lookup_ssid,
    input  logic [RENAME_WIDTH-1:0]          i_lookup_isStore,
    input  sqIdx_t [RENAME_WIDTH-1:0]        i_lookup_sqIdx,
    output logic [RENAME_WIDTH-1:0]          o_dep_vld,
    output sqIdx_t [RENAME_WIDTH-1:0]        o_dep_sqIdx,
    input  logic [ISSUE_WIDTH-1:0]           i_stIssue_vld,
    input  logic [ISSUE_WIDTH-1:0][SW-1:0]   i_stIssue_ssid,
    input  sqIdx_t [ISSUE_WIDTH-1:0]         i_stIssue_sqIdx,
    input  logic                             i_squash_vld,
    input  sqIdx_t                           i_squash_sqIdx,
    output logic [5:0]                       o_validCount
);
    logic [LFST_SIZE-1:0]      valid_q, valid_d;
    sqIdx_t [LFST_SIZE-1:0]    sq_q, sq_d;
    logic [5:0]                count_d;
    logic [RENAME_WIDTH-1:0]   cand, byp_hit;
    sqIdx_t [RENAME_WIDTH-1:0] byp_sq;
    assign cand = i_lookup_vld & i_lookup_isStore;
    for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_slot
        memdep_bypass_sel #(.N(RENAME_WIDTH), .K(k), .SW(SW)) u_sel (
            .cand       (cand),
            .ssid       (i_lookup_ssid),
            .sq_idx     (i_lookup_sqIdx),
            .hit        (byp_hit[k]),
            .hit_sq_idx (byp_sq[k])
        );
        assign o_dep_vld[k] = i_lookup_vld[k] && !i_squash_vld &&
                              (byp_hit[k] || valid_q[i_lookup_ssid[k]]);
        assign o_dep_sqIdx[k] = !i_lookup_vld[k] ? '0 :
                                byp_hit[k] ? byp_sq[k] : sq_q[i_lookup_ssid[k]];
    end
    // clears first, then rename writes so they override clears and higher slots win
    always_comb begin
        valid_d = valid_q;
        sq_d = sq_q;
        count_d = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++)
            if (i_stIssue_vld[p] && valid_q[i_stIssue_ssid[p]] &&
                sq_q[i_stIssue_ssid[p]] == i_stIssue_sqIdx[p])
                valid_d[i_stIssue_ssid[p]] = 1'b0;
        for (int e = 0; e < LFST_SIZE; e++)
            if (i_squash_vld && valid_q[e] && younger_eq(sq_q[e], i_squash_sqIdx))
                valid_d[e] = 1'b0;
        for (int k = 0; k < RENAME_WIDTH; k++)
            if (!i_squash_vld && cand[k]) begin
                valid_d[i_lookup_ssid[k]] = 1'b1;
                sq_d[i_lookup_ssid[k]] = i_lookup_sqIdx[k];
            end
        for (int e = 0; e < LFST_SIZE; e++)
            count_d = count_d + 6'(valid_d[e]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            sq_q <= '0;
            o_validCount <= '0;
        end else begin
            valid_q <= valid_d;
            sq_q <= sq_d;
            o_validCount <= count_d;
        end
    end
endmodule

// File: tb/tb_memdep_lfst.sv
// tb_memdep_lfst: randomized scoreboard bench for the last-fetched-store table
module tb_memdep_lfst;
    import memdep_lfst_pkg::*;
    localparam int RW = 4;
    localparam int IW = 2;
    localparam int NE = 32;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [RW-1:0]       i_lookup_vld, i_lookup_isStore, o_dep_vld;
    logic [RW-1:0][4:0]  i_lookup_ssid;
    sqIdx_t [RW-1:0]     i_lookup_sqIdx, o_dep_sqIdx;
    logic [IW-1:0]       i_stIssue_vld;
    logic [IW-1:0][4:0]  i_stIssue_ssid;
    sqIdx_t [IW-1:0]     i_stIssue_sqIdx;
    logic                i_squash_vld;
    sqIdx_t              i_squash_sqIdx;
    logic [5:0]          o_validCount;
    int total = 0;
    int bad = 0;
    bit     m_v[NE];
    sqIdx_t m_sq[NE];
    typedef struct {
        logic [RW-1:0]   lv;
        logic [RW-1:0]   dv;
        sqIdx_t [RW-1:0] dsq;
        bit              squash;
        int              cnt;
        int              tag;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    memdep_lfst dut (
        .clk(clk), .rst(rst),
        .i_lookup_vld(i_lookup_vld), .i_lookup_ssid(i_lookup_ssid),
        .i_lookup_isStore(i_lookup_isStore), .i_lookup_sqIdx(i_lookup_sqIdx),
        .o_dep_vld(o_dep_vld), .o_dep_sqIdx(o_dep_sqIdx),
        .i_stIssue_vld(i_stIssue_vld), .i_stIssue_ssid(i_stIssue_ssid),
        .i_stIssue_sqIdx(i_stIssue_sqIdx),
        .i_squash_vld(i_squash_vld), .i_squash_sqIdx(i_squash_sqIdx),
        .o_validCount(o_validCount)
    );

    function automatic sqIdx_t mk(int f, int i);
        sqIdx_t s;
        s.flipped = f[0];
        s.idx = i[5:0];
        return s;
    endfunction

    // position on the 128-slot circular order; younger-or-equal means within half a lap ahead
    function automatic int age(sqIdx_t a);
        return int'(a.flipped) * 64 + int'(a.idx);
    endfunction

    function automatic bit yeq(sqIdx_t a, sqIdx_t b);
        return ((age(a) - age(b) + 128) % 128) < 64;
    endfunction

    task automatic chk(int id, string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL [%0d] %s: got %0d expected %0d", id, n, act, exp);
        end
    endtask

    task automatic clr();
        i_lookup_vld = '0;
        i_lookup_isStore = '0;
        i_lookup_ssid = '0;
        i_lookup_sqIdx = '0;
        i_stIssue_vld = '0;
        i_stIssue_ssid = '0;
        i_stIssue_sqIdx = '0;
        i_squash_vld = 1'b0;
        i_squash_sqIdx = '0;
    endtask

    task automatic lk(int k, int s, bit st, sqIdx_t v);
        i_lookup_vld[k] = 1'b1;
        i_lookup_ssid[k] = 5'(s);
        i_lookup_isStore[k] = st;
        i_lookup_sqIdx[k] = v;
    endtask

    task automatic iss(int p, int s, sqIdx_t v);
        i_stIssue_vld[p] = 1'b1;
        i_stIssue_ssid[p] = 5'(s);
        i_stIssue_sqIdx[p] = v;
    endtask

    task automatic model_reset();
        foreach (m_v[i]) begin
            m_v[i] = 1'b0;
            m_sq[i] = '0;
        end
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // push the expected response for the current inputs, then clock and advance the model
    task automatic go(int id);
        exp_t e;
        bit nv[NE];
        sqIdx_t ns[NE];
        e.lv = i_lookup_vld;
        e.squash = i_squash_vld;
        e.tag = id;
        e.cnt = 0;
        e.dv = '0;
        e.dsq = '0;
        foreach (m_v[i]) e.cnt += int'(m_v[i]);
        for (int k = 0; k < RW; k++)
            if (i_lookup_vld[k]) begin
                int j = k - 1;
                while (j >= 0 && !(i_lookup_vld[j] && i_lookup_isStore[j] &&
                                   i_lookup_ssid[j] == i_lookup_ssid[k])) j--;
                if (j >= 0) begin
                    e.dv[k] = 1'b1;
                    e.dsq[k] = i_lookup_sqIdx[j];
                end else begin
                    e.dv[k] = m_v[i_lookup_ssid[k]];
                    e.dsq[k] = m_sq[i_lookup_ssid[k]];
                end
                if (i_squash_vld) e.dv[k] = 1'b0;
            end
        q.push_back(e);
        @(posedge clk);
        nv = m_v;
        ns = m_sq;
        for (int p = 0; p < IW; p++)
            if (i_stIssue_vld[p] && m_v[i_stIssue_ssid[p]] &&
                m_sq[i_stIssue_ssid[p]] == i_stIssue_sqIdx[p])
                nv[i_stIssue_ssid[p]] = 1'b0;
        if (i_squash_vld) begin
            foreach (m_v[i])
                if (m_v[i] && yeq(m_sq[i], i_squash_sqIdx)) nv[i] = 1'b0;
        end else begin
            for (int k = 0; k < RW; k++)
                if (i_lookup_vld[k] && i_lookup_isStore[k]) begin
                    nv[i_lookup_ssid[k]] = 1'b1;
                    ns[i_lookup_ssid[k]] = i_lookup_sqIdx[k];
                end
        end
        m_v = nv;
        m_sq = ns;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < RW; k++) begin
                chk(e.tag, $sformatf("dep_vld[%0d]", k), int'(o_dep_vld[k]), int'(e.dv[k]));
                if (!(e.lv[k] && e.squash))
                    chk(e.tag, $sformatf("dep_sqIdx[%0d]", k), int'(o_dep_sqIdx[k]), int'(e.dsq[k]));
            end
            chk(e.tag, "validCount", int'(o_validCount), e.cnt);
        end
    end

    initial begin
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk(0, "reset validCount", int'(o_validCount), 0);
        chk(0, "reset dep_vld", int'(o_dep_vld), 0);
        rst = 1'b1;
        clr(); lk(0, 3, 0, mk(0, 0)); go(37);
        clr(); lk(0, 5, 1, mk(0, 10)); lk(2, 5, 0, mk(0, 0)); go(38);
        clr(); lk(0, 5, 0, mk(0, 0)); go(38);
        clr(); lk(0, 7, 1, mk(0, 4)); lk(1, 7, 1, mk(0, 5)); go(39);
        clr(); lk(0, 7, 0, mk(0, 0)); iss(0, 7, mk(0, 4)); go(39);
        clr(); lk(0, 7, 0, mk(0, 0)); iss(1, 7, mk(0, 5)); go(39);
        clr(); lk(0, 7, 0, mk(0, 0)); go(39);
        do_reset();
        clr(); lk(0, 1, 1, mk(0, 60)); lk(1, 2, 1, mk(1, 2)); lk(2, 3, 1, mk(0, 20)); go(40);
        clr(); lk(0, 3, 0, mk(0, 0)); i_squash_vld = 1'b1; i_squash_sqIdx = mk(0, 30); go(40);
        clr(); lk(0, 1, 0, mk(0, 0)); lk(1, 2, 0, mk(0, 0)); lk(2, 3, 0, mk(0, 0)); go(40);
        clr(); lk(0, 9, 1, mk(0, 1)); go(41);
        clr(); lk(0, 9, 1, mk(0, 8)); iss(0, 9, mk(0, 1)); go(41);
        clr(); lk(0, 9, 0, mk(0, 0)); go(41);
        clr(); lk(0, 10, 1, mk(0, 3)); lk(1, 11, 1, mk(1, 7)); lk(2, 9, 0, mk(0, 0));
        #2 rst = 1'b0;
        #1;
        chk(42, "async validCount", int'(o_validCount), 0);
        chk(42, "async dep_vld[2]", int'(o_dep_vld[2]), 0);
        clr();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clr(); lk(0, 9, 0, mk(0, 0)); lk(1, 10, 0, mk(0, 0)); lk(2, 11, 0, mk(0, 0)); go(42);
        for (int n = 0; n < 300; n++) begin
            clr();
            for (int k = 0; k < RW; k++)
                if ($urandom_range(0, 3) != 0)
                    lk(k, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                       mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 63))));
            for (int p = 0; p < IW; p++)
                if ($urandom_range(0, 1) == 1) begin
                    int s = int'($urandom_range(0, 7));
                    iss(p, s, $urandom_range(0, 1) == 1 ? m_sq[s] :
                        mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 63))));
                end
            if ($urandom_range(0, 7) == 0) begin
                i_squash_vld = 1'b1;
                i_squash_sqIdx = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            end
            go(100);
        end
        clr();
        repeat (3) @(negedge clk);
        chk(999, "scoreboard drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
